// File: rtl/gigatron_pkg.sv
// gigatron_pkg: shared encodings for the Gigatron core.
// Opcode, mode and bus fields plus branch condition codes.
package gigatron_pkg;

  typedef enum logic [2:0] {
    OP_LD,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_ADD,
    OP_SUB,
    OP_ST,
    OP_BCC
  } op_e;

  typedef enum logic [2:0] {
    MD_D_AC,
    MD_X_AC,
    MD_YD_AC,
    MD_YX_AC,
    MD_D_X,
    MD_D_Y,
    MD_D_OUT,
    MD_YXI_OUT
  } mode_e;

  typedef enum logic [1:0] {
    BUS_D,
    BUS_RAM,
    BUS_AC,
    BUS_IN
  } bus_e;

  localparam logic [2:0] CC_JMP = 3'd0;
  localparam logic [2:0] CC_GT  = 3'd1;
  localparam logic [2:0] CC_LT  = 3'd2;
  localparam logic [2:0] CC_NE  = 3'd3;
  localparam logic [2:0] CC_EQ  = 3'd4;
  localparam logic [2:0] CC_GE  = 3'd5;
  localparam logic [2:0] CC_LE  = 3'd6;
  localparam logic [2:0] CC_BRA = 3'd7;

  localparam logic [15:0] NOP = 16'h0000;

endpackage

// File: rtl/gigatron_alu.sv
// gigatron_alu: combinational ALU and branch condition for the core.
// Conditions test AC as a signed byte against zero.
module gigatron_alu
  import gigatron_pkg::*;
(
  input  op_e        i_op,
  input  logic [2:0] i_mode,
  input  logic [7:0] i_ac,
  input  logic [7:0] i_bus,
  output logic [7:0] o_result,
  output logic       o_taken
);

  logic neg;
  logic zero;

  assign neg  = i_ac[7];
  assign zero = (i_ac == 8'h00);

  always_comb begin
    o_result = i_ac;
    unique case (i_op)
      OP_LD:   o_result = i_bus;
      OP_AND:  o_result = i_ac & i_bus;
      OP_OR:   o_result = i_ac | i_bus;
      OP_XOR:  o_result = i_ac ^ i_bus;
      OP_ADD:  o_result = i_ac + i_bus;
      OP_SUB:  o_result = i_ac + ~i_bus + 8'd1;
      default: o_result = i_ac;
    endcase
  end

  always_comb begin
    o_taken = 1'b0;
    if (i_op == OP_BCC) begin
      unique case (i_mode)
        CC_JMP:  o_taken = 1'b1;
        CC_GT:   o_taken = !neg && !zero;
        CC_LT:   o_taken = neg;
        CC_NE:   o_taken = !zero;
        CC_EQ:   o_taken = zero;
        CC_GE:   o_taken = !neg;
        CC_LE:   o_taken = neg || zero;
        CC_BRA:  o_taken = 1'b1;
        default: o_taken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/gigatron_core.sv
// gigatron_core: two-stage Gigatron CPU with external ROM/RAM ports.
// Define GIGATRON_ROM_WAIT_EN to freeze the core while i_rom_valid is low.
module gigatron_core
  import gigatron_pkg::*;
#(
  parameter int          ROM_AW   = 16,
  parameter int          RAM_AW   = 16,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic              i_clock,
  input  logic              i_reset,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [15:0]       i_rom_data,
  input  logic              i_rom_valid,
  output logic [RAM_AW-1:0] o_ram_addr,
  input  logic [7:0]        i_ram_rdata,
  output logic [7:0]        o_ram_wdata,
  output logic              o_ram_we,
  input  logic [7:0]        i_in,
  output logic [7:0]        o_out,
  output logic [7:0]        o_xout,
  output logic              o_stall
);

  logic [15:0] pc_q, pc_d;
  logic [7:0]  ir_q, ir_d;
  logic [7:0]  d_q, d_d;
  logic [7:0]  ac_q, ac_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [7:0]  out_q, out_d;
  logic [7:0]  xout_q, xout_d;
  logic [7:0]  in_q, in_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;

  logic        stall;
  op_e         op;
  mode_e       mode;
  bus_e        bsel;
  logic [15:0] addr;
  logic [7:0]  bus;
  logic [7:0]  alu_res;
  logic        taken;

`ifdef GIGATRON_ROM_WAIT_EN
  assign stall = ~i_rom_valid;
`else
  logic unused_rom_valid;
  assign unused_rom_valid = i_rom_valid;
  assign stall = 1'b0;
`endif

  assign op   = op_e'(ir_q[7:5]);
  assign mode = mode_e'(ir_q[4:2]);
  assign bsel = bus_e'(ir_q[1:0]);

  // Branches always address RAM at {0,D}.
  always_comb begin
    addr = {8'h00, d_q};
    if (op != OP_BCC) begin
      unique case (mode)
        MD_X_AC:    addr = {8'h00, x_q};
        MD_YD_AC:   addr = {y_q, d_q};
        MD_YX_AC:   addr = {y_q, x_q};
        MD_YXI_OUT: addr = {y_q, x_q};
        default:    addr = {8'h00, d_q};
      endcase
    end
  end

  always_comb begin
    bus = d_q;
    unique case (bsel)
      BUS_D:   bus = d_q;
      BUS_RAM: bus = i_ram_rdata;
      BUS_AC:  bus = ac_q;
      BUS_IN:  bus = in_q;
      default: bus = d_q;
    endcase
  end

  gigatron_alu u_alu (
    .i_op     (op),
    .i_mode   (ir_q[4:2]),
    .i_ac     (ac_q),
    .i_bus    (bus),
    .o_result (alu_res),
    .o_taken  (taken)
  );

  always_comb begin
    pc_d   = pc_q;
    ir_d   = ir_q;
    d_d    = d_q;
    ac_d   = ac_q;
    x_d    = x_q;
    y_d    = y_q;
    out_d  = out_q;
    xout_d = xout_q;
    in_d   = in_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    if (!stall) begin
      ir_d = i_rom_data[7:0];
      d_d  = i_rom_data[15:8];
      pc_d = pc_q + 16'd1;
      hs_d = out_q[6];
      vs_d = out_q[7];
      if (out_q[6] && !hs_q) xout_d = ac_q;
      if (out_q[7] && !vs_q) in_d = i_in;
      if (op == OP_BCC) begin
        if (taken) begin
          if (ir_q[4:2] == CC_JMP) pc_d = {y_q, bus};
          else pc_d = {pc_q[15:8], bus};
        end
      end else begin
        if (op == OP_ST) begin
          if (mode == MD_D_X) x_d = alu_res;
          if (mode == MD_D_Y) y_d = alu_res;
        end else begin
          unique case (mode)
            MD_D_AC, MD_X_AC,
            MD_YD_AC, MD_YX_AC: ac_d = alu_res;
            MD_D_X:             x_d = alu_res;
            MD_D_Y:             y_d = alu_res;
            default:            out_d = alu_res;
          endcase
        end
        if (mode == MD_YXI_OUT) x_d = x_q + 8'd1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      pc_q   <= RESET_PC;
      ir_q   <= NOP[7:0];
      d_q    <= NOP[15:8];
      ac_q   <= 8'h00;
      x_q    <= 8'h00;
      y_q    <= 8'h00;
      out_q  <= 8'h00;
      xout_q <= 8'h00;
      in_q   <= 8'h00;
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      d_q    <= d_d;
      ac_q   <= ac_d;
      x_q    <= x_d;
      y_q    <= y_d;
      out_q  <= out_d;
      xout_q <= xout_d;
      in_q   <= in_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
    end
  end

  assign o_rom_addr  = pc_q[ROM_AW-1:0];
  assign o_ram_addr  = addr[RAM_AW-1:0];
  assign o_ram_wdata = bus;
  assign o_ram_we    = (op == OP_ST) && !stall && !i_reset;
  assign o_out       = out_q;
  assign o_xout      = xout_q;
  assign o_stall     = stall;

endmodule

// File: tb/tb_gigatron_core.sv
// tb_gigatron_core: directed scenarios plus a random-ROM run
// checked against an instruction-level model of the Gigatron.
module tb_gigatron_core;

  localparam int LD = 0, AND_ = 1, OR_ = 2, XOR_ = 3;
  localparam int ADD = 4, SUB = 5, ST = 6, BCC = 7;
  localparam int B_D = 0, B_RAM = 1, B_AC = 2, B_IN = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b1;
  logic [7:0]  in_v = 8'h00;
  logic [15:0] rom_addr;
  logic [15:0] rom_data;
  logic [15:0] ram_addr;
  logic [7:0]  ram_rdata;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  out_v;
  logic [7:0]  xout_v;
  logic        stall;

  logic [15:0] rom [0:65535];
  logic [7:0]  ram [0:65535];
  logic        written [0:65535];
  logic [7:0]  mram [0:65535];

  int n_tests = 0;
  int n_fail = 0;
  int n_writes = 0;

  logic [15:0] m_pc, m_npc;
  logic [7:0]  m_ac, m_x, m_y, m_out, m_xout, m_in;
  logic        m_hs, m_vs;

  always #5 clk = ~clk;

  function automatic logic [7:0] h(input logic [15:0] a);
    logic [7:0] p;
    p = a[7:0] * 8'd37;
    return p ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [15:0] ins(input int op, input int md,
                                      input int bs, input int d);
    logic [15:0] w;
    w = {d[7:0], op[2:0], md[2:0], bs[1:0]};
    return w;
  endfunction

  assign rom_data  = rom[rom_addr];
  assign ram_rdata = written[ram_addr] ? ram[ram_addr] : h(ram_addr);

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 65536; i++) written[i] <= 1'b0;
    end else if (ram_we) begin
      ram[ram_addr]     <= ram_wdata;
      written[ram_addr] <= 1'b1;
      n_writes          <= n_writes + 1;
    end
  end

  gigatron_core #(
    .ROM_AW   (16),
    .RAM_AW   (16),
    .RESET_PC (16'h0100)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .o_rom_addr  (rom_addr),
    .i_rom_data  (rom_data),
    .i_rom_valid (valid),
    .o_ram_addr  (ram_addr),
    .i_ram_rdata (ram_rdata),
    .o_ram_wdata (ram_wdata),
    .o_ram_we    (ram_we),
    .i_in        (in_v),
    .o_out       (out_v),
    .o_xout      (xout_v),
    .o_stall     (stall)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 65536; i++) rom[i] = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    valid = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] exp;
    clear_rom();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp = 16'h0100 + 16'(i);
      n_tests++;
      if (rom_addr !== exp) begin
        n_fail++;
        $display("FAIL reset_seq%0d: rom_addr=%h want %h", i, rom_addr, exp);
      end
      step(1);
    end
    n_tests++;
    if (out_v !== 8'h00 || xout_v !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_out: out=%h xout=%h want 00/00", out_v, xout_v);
    end
    for (int i = 16'h0100; i < 16'h0110; i++) rom[i] = ins(ST, 0, B_D, 8'h10);
    do_reset();
    step(2);
    n_tests++;
    if (ram_we !== 1'b1) begin
      n_fail++;
      $display("FAIL st_we: we=%b want 1", ram_we);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (ram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_we: we=%b want 0", ram_we);
    end
  endtask

  task automatic test_alu();
    clear_rom();
    rom[16'h0100] = ins(LD, 6, B_D, 8'h55);
    rom[16'h0101] = ins(LD, 0, B_D, 8'h5A);
    rom[16'h0102] = ins(ADD, 0, B_D, 8'hA6);
    rom[16'h0103] = ins(LD, 6, B_AC, 0);
    rom[16'h0104] = ins(SUB, 0, B_D, 8'h01);
    rom[16'h0105] = ins(LD, 6, B_AC, 0);
    do_reset();
    step(2);
    n_tests++;
    if (out_v !== 8'h55) begin
      n_fail++;
      $display("FAIL alu_out55: out=%h want 55", out_v);
    end
    step(3);
    n_tests++;
    if (out_v !== 8'h00) begin
      n_fail++;
      $display("FAIL alu_add_wrap: out=%h want 00", out_v);
    end
    step(2);
    n_tests++;
    if (out_v !== 8'hFF) begin
      n_fail++;
      $display("FAIL alu_sub: out=%h want ff", out_v);
    end
  endtask

  task automatic test_xinc();
    logic [7:0] exp;
    clear_rom();
    rom[16'h0100] = ins(LD, 5, B_D, 8'h03);
    rom[16'h0101] = ins(LD, 4, B_D, 8'hFF);
    rom[16'h0102] = ins(ST, 7, B_D, 8'h77);
    rom[16'h0103] = ins(LD, 3, B_RAM, 0);
    rom[16'h0104] = ins(LD, 6, B_AC, 0);
    do_reset();
    step(3);
    n_tests++;
    if (ram_we !== 1'b1 || ram_addr !== 16'h03FF || ram_wdata !== 8'h77) begin
      n_fail++;
      $display("FAIL xinc_st: we=%b addr=%h wd=%h want 1/03ff/77",
               ram_we, ram_addr, ram_wdata);
    end
    step(1);
    n_tests++;
    if (written[16'h03FF] !== 1'b1 || ram[16'h03FF] !== 8'h77) begin
      n_fail++;
      $display("FAIL xinc_mem: ram[03ff]=%h want 77", ram[16'h03FF]);
    end
    n_tests++;
    if (ram_addr !== 16'h0300) begin
      n_fail++;
      $display("FAIL xinc_wrap: addr=%h want 0300", ram_addr);
    end
    step(2);
    exp = h(16'h0300);
    n_tests++;
    if (out_v !== exp) begin
      n_fail++;
      $display("FAIL xinc_ld: out=%h want %h", out_v, exp);
    end
  endtask

  task automatic test_branch(input logic [7:0] acv, input logic [15:0] exp_pc,
                             input logic [7:0] exp_out);
    clear_rom();
    rom[16'h0100] = ins(LD, 5, B_D, 8'h02);
    rom[16'h0101] = ins(BCC, 0, B_D, 8'h10);
    rom[16'h0102] = ins(LD, 0, B_D, int'(acv));
    rom[16'h0210] = ins(BCC, 2, B_D, 8'h40);
    rom[16'h0211] = ins(LD, 6, B_D, 8'h11);
    rom[16'h0212] = ins(LD, 6, B_D, 8'h33);
    rom[16'h0240] = ins(LD, 6, B_D, 8'h22);
    do_reset();
    step(3);
    n_tests++;
    if (rom_addr !== 16'h0210) begin
      n_fail++;
      $display("FAIL br_far: rom_addr=%h want 0210", rom_addr);
    end
    step(2);
    n_tests++;
    if (rom_addr !== exp_pc) begin
      n_fail++;
      $display("FAIL br_blt_%h: rom_addr=%h want %h", acv, rom_addr, exp_pc);
    end
    step(1);
    n_tests++;
    if (out_v !== 8'h11) begin
      n_fail++;
      $display("FAIL br_slot: out=%h want 11", out_v);
    end
    step(1);
    n_tests++;
    if (out_v !== exp_out) begin
      n_fail++;
      $display("FAIL br_dest_%h: out=%h want %h", acv, out_v, exp_out);
    end
  endtask

  task automatic test_boundaries();
    clear_rom();
    rom[16'h0100] = ins(LD, 5, B_D, 8'h01);
    rom[16'h0101] = ins(BCC, 0, B_D, 8'hFE);
    rom[16'h01FE] = ins(BCC, 4, B_D, 8'h20);
    rom[16'h01FF] = ins(LD, 6, B_D, 8'h11);
    do_reset();
    step(5);
    n_tests++;
    if (rom_addr !== 16'h0120) begin
      n_fail++;
      $display("FAIL pcl_ff_jump: rom_addr=%h want 0120", rom_addr);
    end
    clear_rom();
    rom[16'h0100] = ins(LD, 5, B_D, 8'hFF);
    rom[16'h0101] = ins(BCC, 0, B_D, 8'hFF);
    rom[16'hFFFF] = ins(LD, 6, B_D, 8'h44);
    rom[16'h0000] = ins(LD, 6, B_D, 8'h55);
    do_reset();
    step(4);
    n_tests++;
    if (rom_addr !== 16'h0000) begin
      n_fail++;
      $display("FAIL pc_wrap: rom_addr=%h want 0000", rom_addr);
    end
    step(2);
    n_tests++;
    if (out_v !== 8'h55) begin
      n_fail++;
      $display("FAIL pc_wrap_exec: out=%h want 55", out_v);
    end
  endtask

  task automatic test_xout();
    clear_rom();
    rom[16'h0100] = ins(LD, 0, B_D, 8'hC3);
    rom[16'h0101] = ins(LD, 6, B_D, 8'h40);
    rom[16'h0102] = ins(LD, 0, B_D, 8'h55);
    rom[16'h0103] = ins(LD, 6, B_D, 8'h41);
    rom[16'h0104] = ins(LD, 0, B_D, 8'h66);
    rom[16'h0105] = ins(LD, 6, B_D, 8'h00);
    rom[16'h0106] = ins(LD, 6, B_D, 8'h40);
    do_reset();
    step(3);
    n_tests++;
    if (out_v !== 8'h40 || xout_v !== 8'h00) begin
      n_fail++;
      $display("FAIL xout_early: out=%h xout=%h want 40/00", out_v, xout_v);
    end
    step(1);
    n_tests++;
    if (xout_v !== 8'hC3) begin
      n_fail++;
      $display("FAIL xout_latch: xout=%h want c3", xout_v);
    end
    step(3);
    n_tests++;
    if (xout_v !== 8'hC3) begin
      n_fail++;
      $display("FAIL xout_hold: xout=%h want c3", xout_v);
    end
    step(2);
    n_tests++;
    if (xout_v !== 8'h66) begin
      n_fail++;
      $display("FAIL xout_relatch: xout=%h want 66", xout_v);
    end
  endtask

`ifdef GIGATRON_ROM_WAIT_EN
  task automatic test_stall();
    int w0;
    clear_rom();
    rom[16'h0100] = ins(LD, 0, B_D, 8'h21);
    rom[16'h0101] = ins(ST, 0, B_AC, 8'h80);
    rom[16'h0102] = ins(LD, 6, B_AC, 0);
    rom[16'h0103] = ins(LD, 0, B_D, 8'h99);
    rom[16'h0104] = ins(LD, 6, B_AC, 0);
    do_reset();
    step(2);
    w0 = n_writes;
    valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (stall !== 1'b1 || ram_we !== 1'b0 || rom_addr !== 16'h0102) begin
        n_fail++;
        $display("FAIL stall%0d: stall=%b we=%b pc=%h want 1/0/0102",
                 i, stall, ram_we, rom_addr);
      end
      step(1);
    end
    valid = 1'b1;
    #1;
    n_tests++;
    if (ram_we !== 1'b1 || n_writes != w0) begin
      n_fail++;
      $display("FAIL stall_release: we=%b writes=%0d want 1/0",
               ram_we, n_writes - w0);
    end
    step(1);
    n_tests++;
    if (n_writes - w0 != 1 || ram[16'h0080] !== 8'h21) begin
      n_fail++;
      $display("FAIL stall_write: writes=%0d data=%h want 1/21",
               n_writes - w0, ram[16'h0080]);
    end
    step(1);
    n_tests++;
    if (out_v !== 8'h21) begin
      n_fail++;
      $display("FAIL stall_ac: out=%h want 21", out_v);
    end
  endtask
`else
  task automatic test_stall();
    do_reset();
    valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      n_tests++;
      if (stall !== 1'b0 || rom_addr !== 16'h0101 + 16'(i)) begin
        n_fail++;
        $display("FAIL no_stall%0d: stall=%b pc=%h", i, stall, rom_addr);
      end
    end
    valid = 1'b1;
  endtask
`endif

  task automatic model_step(output logic ew, output logic [15:0] ea,
                            output logic [7:0] ed);
    logic [15:0] w, a, nn;
    logic [2:0]  op, md;
    logic [1:0]  bs;
    logic [7:0]  dd, bus, r;
    logic signed [7:0] sac;
    logic tk;
    w  = rom[m_pc];
    op = w[7:5];
    md = w[4:2];
    bs = w[1:0];
    dd = w[15:8];
    a = {8'h00, dd};
    if (op != 3'd7) begin
      case (md)
        3'd1: a = {8'h00, m_x};
        3'd2: a = {m_y, dd};
        3'd3, 3'd7: a = {m_y, m_x};
        default: a = {8'h00, dd};
      endcase
    end
    case (bs)
      2'd0: bus = dd;
      2'd1: bus = mram[a];
      2'd2: bus = m_ac;
      default: bus = m_in;
    endcase
    case (op)
      3'd0: r = bus;
      3'd1: r = m_ac & bus;
      3'd2: r = m_ac | bus;
      3'd3: r = m_ac ^ bus;
      3'd4: r = m_ac + bus;
      3'd5: r = m_ac - bus;
      default: r = m_ac;
    endcase
    sac = m_ac;
    case (md)
      3'd1: tk = sac > 0;
      3'd2: tk = sac < 0;
      3'd3: tk = sac != 0;
      3'd4: tk = sac == 0;
      3'd5: tk = sac >= 0;
      3'd6: tk = sac <= 0;
      default: tk = 1'b1;
    endcase
    if (m_out[6] && !m_hs) m_xout = m_ac;
    if (m_out[7] && !m_vs) m_in = in_v;
    m_hs = m_out[6];
    m_vs = m_out[7];
    ew = (op == 3'd6);
    ea = a;
    ed = bus;
    nn = m_npc + 16'd1;
    if (op == 3'd7) begin
      if (tk) nn = (md == 3'd0) ? {m_y, bus} : {m_npc[15:8], bus};
    end else begin
      if (op == 3'd6) begin
        mram[a] = bus;
        if (md == 3'd4) m_x = r;
        if (md == 3'd5) m_y = r;
      end else begin
        case (md)
          3'd4: m_x = r;
          3'd5: m_y = r;
          3'd6, 3'd7: m_out = r;
          default: m_ac = r;
        endcase
      end
      if (md == 3'd7) m_x = m_x + 8'd1;
    end
    m_pc = m_npc;
    m_npc = nn;
  endtask

  task automatic test_random();
    logic        ew;
    logic [15:0] ea;
    logic [7:0]  ed, v;
    int bad;
    for (int i = 0; i < 65536; i++) begin
      rom[i]  = 16'($urandom);
      mram[i] = h(16'(i));
    end
    do_reset();
    m_pc = 16'h0100;
    m_npc = 16'h0101;
    m_ac = 0; m_x = 0; m_y = 0; m_out = 0;
    m_xout = 0; m_in = 0; m_hs = 0; m_vs = 0;
    step(1);
    for (int c = 0; c < 400; c++) begin
      n_tests++;
      if (rom_addr !== m_npc || out_v !== m_out || xout_v !== m_xout) begin
        n_fail++;
        $display("FAIL rnd_state%0d: pc=%h out=%h xout=%h want %h/%h/%h",
                 c, rom_addr, out_v, xout_v, m_npc, m_out, m_xout);
      end
      in_v = 8'($urandom);
      model_step(ew, ea, ed);
      n_tests++;
      if (ram_we !== ew || (ew && (ram_addr !== ea || ram_wdata !== ed))) begin
        n_fail++;
        $display("FAIL rnd_write%0d: we=%b addr=%h wd=%h want %b/%h/%h",
                 c, ram_we, ram_addr, ram_wdata, ew, ea, ed);
      end
      step(1);
    end
    bad = 0;
    for (int a = 0; a < 65536; a++) begin
      v = written[a] ? ram[a] : h(16'(a));
      if (v !== mram[a]) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL rnd_ram: %0d bytes differ, want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_xinc();
    test_branch(8'h80, 16'h0240, 8'h22);
    test_branch(8'h00, 16'h0212, 8'h33);
    test_boundaries();
    test_xout();
    test_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
